// File: rtl/vr_mem_responder_if.sv
// VeriRISC control-bus port bundle between the CPU sequencer (master) and the
// memory responder (slave), including the backdoor preload port.
interface vr_mem_responder_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              wr_ack;
    logic              busy;
    logic              err;
    logic [CNT_W-1:0]  rd_count;
    logic [CNT_W-1:0]  wr_count;
    logic              init_en;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;

    modport master (
        output mem_rd, mem_wr, addr, data_in, init_en, init_addr, init_data,
        input  data_out, rd_valid, wr_ack, busy, err, rd_count, wr_count
    );

    modport slave (
        input  mem_rd, mem_wr, addr, data_in, init_en, init_addr, init_data,
        output data_out, rd_valid, wr_ack, busy, err, rd_count, wr_count
    );
endinterface

// File: rtl/vr_mem_responder.sv
// Memory-side responder for the VeriRISC control bus: level-held read/write
// strobes against an internal array, with read latency, error flag and counters.
module vr_mem_responder #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1,  // legal range 1..4
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    vr_mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        READ_HOLD,
        WRITE_HOLD
    } state_t;

    localparam logic [1:0] LAT_LOAD = 2'(READ_LAT - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] cap_addr_q;
    logic [1:0]        lat_cnt_q;
    logic [DATA_W-1:0] data_out_q;
    logic              rd_valid_q;
    logic              wr_ack_q;
    logic              err_q;
    logic [CNT_W-1:0]  rd_count_q, rd_count_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Bus writes and backdoor preloads share one port; both only land in IDLE.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.addr;
        mem_wdata = bus.data_in;
        if (rst && state_q == IDLE && !bus.mem_rd) begin
            if (bus.mem_wr) begin
                mem_we = 1'b1;
            end else if (bus.init_en) begin
                mem_we    = 1'b1;
                mem_waddr = bus.init_addr;
                mem_wdata = bus.init_data;
            end
        end
    end

    always_comb begin
        rd_count_d = (rd_count_q == '1) ? rd_count_q : rd_count_q + CNT_W'(1);
        wr_count_d = (wr_count_q == '1) ? wr_count_q : wr_count_q + CNT_W'(1);
    end

    // NOTE: the array has no reset so it maps onto plain RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // NOTE: asynchronous active-low reset; every state register uses <= only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cap_addr_q <= '0;
            lat_cnt_q  <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            wr_ack_q   <= 1'b0;
            err_q      <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            wr_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.mem_rd && bus.mem_wr) begin
                        err_q <= 1'b1;
                    end else if (bus.mem_rd) begin
                        cap_addr_q <= bus.addr;
                        lat_cnt_q  <= LAT_LOAD;
                        state_q    <= READ_WAIT;
                    end else if (bus.mem_wr) begin
                        wr_ack_q   <= 1'b1;
                        wr_count_q <= wr_count_d;
                        state_q    <= WRITE_HOLD;
                    end
                end
                READ_WAIT: begin
                    if (bus.mem_wr) err_q <= 1'b1;
                    if (!bus.mem_rd) begin
                        state_q <= IDLE;
                    end else if (lat_cnt_q != 2'd0) begin
                        lat_cnt_q <= lat_cnt_q - 2'd1;
                    end else begin
                        data_out_q <= mem_q[cap_addr_q];
                        rd_valid_q <= 1'b1;
                        rd_count_q <= rd_count_d;
                        state_q    <= READ_HOLD;
                    end
                end
                READ_HOLD: begin
                    if (bus.mem_wr) err_q <= 1'b1;
                    if (!bus.mem_rd) begin
                        rd_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end else if (bus.addr != cap_addr_q) begin
                        // New address mid-hold restarts the full read latency.
                        rd_valid_q <= 1'b0;
                        cap_addr_q <= bus.addr;
                        lat_cnt_q  <= LAT_LOAD;
                        state_q    <= READ_WAIT;
                    end
                end
                WRITE_HOLD: begin
                    if (bus.mem_rd) err_q <= 1'b1;
                    if (!bus.mem_wr) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.wr_ack   = wr_ack_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.err      = err_q;
    assign bus.rd_count = rd_count_q;
    assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_vr_mem_responder.sv
// Self-checking bench for vr_mem_responder: two instances (latency 1 / 8-bit
// counters and latency 3 / 2-bit counters) share one stimulus stream.
module tb_vr_mem_responder;

    typedef struct {
        bit       rd;
        bit       wr;
        bit [4:0] addr;
        bit [7:0] din;
        bit       ie;
        bit [4:0] ia;
        bit [7:0] id;
        bit       ev;
        bit [7:0] ed;
        bit       eack;
        bit       ebusy;
        bit       eerr;
        int       erdc;
        int       ewrc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd = 1'b0, wr = 1'b0, ie = 1'b0;
    logic [4:0] addr = '0, ia = '0;
    logic [7:0] din = '0, id = '0;

    int n_vec = 0;
    int n_bad = 0;

    vr_mem_responder_if #(.ADDR_W(5), .DATA_W(8), .CNT_W(8)) bus_a ();
    vr_mem_responder_if #(.ADDR_W(5), .DATA_W(8), .CNT_W(2)) bus_b ();

    assign bus_a.mem_rd    = rd;
    assign bus_a.mem_wr    = wr;
    assign bus_a.addr      = addr;
    assign bus_a.data_in   = din;
    assign bus_a.init_en   = ie;
    assign bus_a.init_addr = ia;
    assign bus_a.init_data = id;
    assign bus_b.mem_rd    = rd;
    assign bus_b.mem_wr    = wr;
    assign bus_b.addr      = addr;
    assign bus_b.data_in   = din;
    assign bus_b.init_en   = ie;
    assign bus_b.init_addr = ia;
    assign bus_b.init_data = id;

    vr_mem_responder #(.ADDR_W(5), .DATA_W(8), .READ_LAT(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    vr_mem_responder #(.ADDR_W(5), .DATA_W(8), .READ_LAT(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    always #5 clk = ~clk;

    // Reference model, one slot per instance: a read is "in flight" for a number
    // of edges, then "valid" until the strobe drops or the address moves.
    int unsigned m_lat [2] = '{1, 3};
    int unsigned m_max [2] = '{255, 3};
    bit          m_rd_act [2];
    bit          m_wr_act [2];
    bit          m_valid [2];
    bit          m_ack [2];
    bit          m_err [2];
    int unsigned m_left [2];
    int unsigned m_rdc [2];
    int unsigned m_wrc [2];
    bit [4:0]    m_cap [2];
    bit [7:0]    m_dout [2];
    bit [7:0]    m_mem [2][32];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rd_act[i] = 1'b0; m_wr_act[i] = 1'b0; m_valid[i] = 1'b0;
            m_ack[i] = 1'b0; m_err[i] = 1'b0; m_left[i] = 0;
            m_rdc[i] = 0; m_wrc[i] = 0; m_cap[i] = '0; m_dout[i] = '0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_ack[i] = 1'b0;
            if (m_rd_act[i]) begin
                if (wr) m_err[i] = 1'b1;
                if (!rd) begin
                    m_rd_act[i] = 1'b0;
                    m_valid[i]  = 1'b0;
                end else if (m_valid[i]) begin
                    if (addr != m_cap[i]) begin
                        m_valid[i] = 1'b0;
                        m_cap[i]   = addr;
                        m_left[i]  = m_lat[i];
                    end
                end else begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) begin
                        m_valid[i] = 1'b1;
                        m_dout[i]  = m_mem[i][m_cap[i]];
                        if (m_rdc[i] < m_max[i]) m_rdc[i] = m_rdc[i] + 1;
                    end
                end
            end else if (m_wr_act[i]) begin
                if (rd) m_err[i] = 1'b1;
                if (!wr) m_wr_act[i] = 1'b0;
            end else if (rd && wr) begin
                m_err[i] = 1'b1;
            end else if (rd) begin
                m_rd_act[i] = 1'b1;
                m_cap[i]    = addr;
                m_left[i]   = m_lat[i];
            end else if (wr) begin
                m_mem[i][addr] = din;
                m_ack[i]    = 1'b1;
                m_wr_act[i] = 1'b1;
                if (m_wrc[i] < m_max[i]) m_wrc[i] = m_wrc[i] + 1;
            end else if (ie) begin
                m_mem[i][ia] = id;
            end
        end
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_vals(input string tag,
                              input int unsigned v, d, ack, bsy, er, rc, wc,
                              input int unsigned ev, ed, eack, ebsy, eer, erc, ewc);
        check({tag, " rd_valid"}, v, ev);
        check({tag, " data_out"}, d, ed);
        check({tag, " wr_ack"}, ack, eack);
        check({tag, " busy"}, bsy, ebsy);
        check({tag, " err"}, er, eer);
        check({tag, " rd_count"}, rc, erc);
        check({tag, " wr_count"}, wc, ewc);
    endtask

    task automatic check_a(input string tag, input int unsigned ev, ed, eack, ebsy, eer, erc, ewc);
        check_vals({"A ", tag}, 32'(bus_a.rd_valid), 32'(bus_a.data_out), 32'(bus_a.wr_ack),
                   32'(bus_a.busy), 32'(bus_a.err), 32'(bus_a.rd_count), 32'(bus_a.wr_count),
                   ev, ed, eack, ebsy, eer, erc, ewc);
    endtask

    task automatic check_b(input string tag, input int unsigned ev, ed, eack, ebsy, eer, erc, ewc);
        check_vals({"B ", tag}, 32'(bus_b.rd_valid), 32'(bus_b.data_out), 32'(bus_b.wr_ack),
                   32'(bus_b.busy), 32'(bus_b.err), 32'(bus_b.rd_count), 32'(bus_b.wr_count),
                   ev, ed, eack, ebsy, eer, erc, ewc);
    endtask

    task automatic check_model(input string tag);
        check_a(tag, 32'(m_valid[0]), 32'(m_dout[0]), 32'(m_ack[0]), 32'(m_rd_act[0] | m_wr_act[0]),
                32'(m_err[0]), m_rdc[0], m_wrc[0]);
        check_b(tag, 32'(m_valid[1]), 32'(m_dout[1]), 32'(m_ack[1]), 32'(m_rd_act[1] | m_wr_act[1]),
                32'(m_err[1]), m_rdc[1], m_wrc[1]);
    endtask

    // Called at a falling edge; asserts reset right away so no edge is lost.
    task automatic do_reset();
        rst = 1'b0; rd = 1'b0; wr = 1'b0; ie = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
    endtask

    task automatic read_b7(input int hold);
        rd = 1'b1; addr = 5'd7;
        repeat (hold) cycle();
        rd = 1'b0;
        cycle();
    endtask

    vec_t tbl [24];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // rd wr addr din ie ia id | valid data ack busy err rdc wrc (instance A, latency 1)
        tbl[0]  = '{0, 0, 0, 8'h00, 1, 3, 8'hA5, 0, 8'h00, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 8'h00, 1, 2, 8'h11, 0, 8'h00, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 8'h00, 1, 4, 8'h22, 0, 8'h00, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 3, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0};
        tbl[4]  = '{1, 0, 3, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 0, 1, 0, 1, 0};
        tbl[5]  = '{1, 0, 3, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 0, 1, 0, 1, 0};
        tbl[6]  = '{0, 0, 3, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 0, 0, 1, 0};
        tbl[7]  = '{0, 1, 9, 8'h5A, 0, 0, 8'h00, 0, 8'hA5, 1, 1, 0, 1, 1};
        tbl[8]  = '{0, 1, 9, 8'h5A, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 1, 1};
        tbl[9]  = '{0, 1, 9, 8'h5A, 1, 3, 8'h00, 0, 8'hA5, 0, 1, 0, 1, 1};
        tbl[10] = '{0, 0, 9, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 0, 0, 1, 1};
        tbl[11] = '{1, 0, 9, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 0, 1, 1};
        tbl[12] = '{1, 0, 9, 8'h00, 0, 0, 8'h00, 1, 8'h5A, 0, 1, 0, 2, 1};
        tbl[13] = '{0, 0, 9, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 0, 0, 0, 2, 1};
        tbl[14] = '{1, 0, 2, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 0, 1, 0, 2, 1};
        tbl[15] = '{1, 0, 2, 8'h00, 0, 0, 8'h00, 1, 8'h11, 0, 1, 0, 3, 1};
        tbl[16] = '{1, 0, 4, 8'h00, 0, 0, 8'h00, 0, 8'h11, 0, 1, 0, 3, 1};
        tbl[17] = '{1, 0, 4, 8'h00, 0, 0, 8'h00, 1, 8'h22, 0, 1, 0, 4, 1};
        tbl[18] = '{0, 0, 4, 8'h00, 0, 0, 8'h00, 0, 8'h22, 0, 0, 0, 4, 1};
        tbl[19] = '{1, 1, 3, 8'hFF, 0, 0, 8'h00, 0, 8'h22, 0, 0, 1, 4, 1};
        tbl[20] = '{0, 0, 3, 8'h00, 0, 0, 8'h00, 0, 8'h22, 0, 0, 1, 4, 1};
        tbl[21] = '{1, 0, 3, 8'h00, 0, 0, 8'h00, 0, 8'h22, 0, 1, 1, 4, 1};
        tbl[22] = '{1, 1, 3, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 0, 1, 1, 5, 1};
        tbl[23] = '{0, 0, 3, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 0, 1, 5, 1};

        do_reset();
        check_a("reset", 0, 0, 0, 0, 0, 0, 0);
        check_b("reset", 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 24; k++) begin
            rd = tbl[k].rd; wr = tbl[k].wr; addr = tbl[k].addr; din = tbl[k].din;
            ie = tbl[k].ie; ia = tbl[k].ia; id = tbl[k].id;
            cycle();
            check_a($sformatf("vec%0d", k), 32'(tbl[k].ev), 32'(tbl[k].ed), 32'(tbl[k].eack),
                    32'(tbl[k].ebusy), 32'(tbl[k].eerr), 32'(tbl[k].erdc), 32'(tbl[k].ewrc));
        end
        ie = 1'b0;

        // Latency 3: valid only on the third edge after capture.
        do_reset();
        ie = 1'b1; ia = 5'd7; id = 8'h3C;
        cycle();
        ie = 1'b0; rd = 1'b1; addr = 5'd7;
        cycle();
        check_b("lat E0", 0, 0, 0, 1, 0, 0, 0);
        cycle();
        check_b("lat E1", 0, 0, 0, 1, 0, 0, 0);
        cycle();
        check_b("lat E2", 0, 0, 0, 1, 0, 0, 0);
        cycle();
        check_b("lat E3", 1, 8'h3C, 0, 1, 0, 1, 0);
        rd = 1'b0;
        cycle();
        check_b("lat release", 0, 8'h3C, 0, 0, 0, 1, 0);

        // Abort: strobe dropped before the latency expires.
        do_reset();
        rd = 1'b1; addr = 5'd7;
        cycle();
        rd = 1'b0;
        repeat (4) cycle();
        check_b("abort", 0, 0, 0, 0, 0, 0, 0);

        // Five completed reads: the 2-bit counter pins at 3, the 8-bit one reaches 5.
        for (int k = 0; k < 5; k++) read_b7(4);
        check_b("saturate", 0, 8'h3C, 0, 0, 0, 3, 0);
        check_a("no saturate", 0, 8'h3C, 0, 0, 0, 5, 0);

        // Asynchronous reset while B is still waiting on its latency.
        rd = 1'b1; addr = 5'd7;
        cycle();
        cycle();
        check_b("mid read busy", 0, 8'h3C, 0, 1, 0, 3, 0);
        rst = 1'b0;
        #1;
        check_b("async reset", 0, 0, 0, 0, 0, 0, 0);
        check_a("async reset", 0, 0, 0, 0, 0, 0, 0);
        rd = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        rd = 1'b1; addr = 5'd7;
        repeat (3) cycle();
        check_b("retained E2", 0, 0, 0, 1, 0, 0, 0);
        cycle();
        check_b("retained", 1, 8'h3C, 0, 1, 0, 1, 0);
        check_a("retained", 1, 8'h3C, 0, 1, 0, 1, 0);

        // Randomised traffic against the model, with the whole array preloaded first.
        do_reset();
        for (int a = 0; a < 32; a++) begin
            ie = 1'b1; ia = 5'(a); id = 8'($urandom);
            cycle();
        end
        ie = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) do_reset();
            if ($urandom_range(0, 9) < 2) rd = ~rd;
            if ($urandom_range(0, 19) < 2) wr = ~wr;
            if ($urandom_range(0, 9) == 0) addr = 5'($urandom);
            din = 8'($urandom);
            ie  = ($urandom_range(0, 3) == 0);
            ia  = 5'($urandom);
            id  = 8'($urandom);
            cycle();
            check_model($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
